conv_8_4_host: RTL and testbench

CONV_8_4_HOST -- requirements
Module: conv_8_4_host

---
 rtl/conv_pkg.sv | 21 ++
 rtl/stream_src.sv | 71 +++++++
 rtl/conv_8_4_host.sv | 170 +++++++++++++++++
 tb/tb_conv_8_4_host.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution host: default geometry, result depth
// and the job-control state encoding.
package conv_pkg;

    localparam int N_DEF         = 8;
    localparam int M_DEF         = 4;
    localparam int WD_DEF        = 8;
    localparam int WY_DEF        = 18;
    localparam int RES_DEPTH_DEF = N_DEF - M_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int res_depth(input int n, input int m);
        return n - m + 1;
    endfunction

endpackage

// File: rtl/stream_src.sv
// Buffer-backed stream source: holds DEPTH samples loaded through a write port
// and streams them out in index order over a valid/ready interface.
module stream_src #(
    parameter int DEPTH = 8,
    parameter int WD    = 8,
    parameter int AW    = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          run,
    input  logic          stall,
    input  logic          ready,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [WD-1:0] wr_data,
    output logic [WD-1:0] data,
    output logic          valid,
    output logic          all_sent
);

    logic [WD-1:0] mem_q [DEPTH];
    logic [WD-1:0] mem_d [DEPTH];
    logic [CW-1:0] sent_q;
    logic [CW-1:0] sent_d;
    logic [WD-1:0] rd_word;

    // Addresses beyond DEPTH match no entry and are silently dropped.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (int'(wr_addr) == i)) begin
                mem_d[i] = wr_data;
            end
        end
    end

    always_comb begin
        all_sent = (sent_q == CW'(DEPTH));
        rd_word  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sent_q == CW'(i)) begin
                rd_word = mem_q[i];
            end
        end
        // Stall only masks valid; a masked beat never counts as a transfer.
        valid  = run && !all_sent && !stall;
        data   = valid ? rd_word : '0;
        sent_d = sent_q;
        if (clear) begin
            sent_d = '0;
        end else if (valid && ready) begin
            sent_d = sent_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

    // Sample storage is deliberately outside reset so vectors survive an abort.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/conv_8_4_host.sv
// Job host for a streaming convolution engine: sources x and f vectors, collects
// y results into a readable buffer and sequences one job per start request.
module conv_8_4_host
    import conv_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int M  = M_DEF,
    parameter int WD = WD_DEF,
    parameter int WY = WY_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_wr_en,
    input  logic          cfg_sel,
    input  logic [2:0]    cfg_addr,
    input  logic [WD-1:0] cfg_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [WD-1:0] m_data_x,
    output logic          m_valid_x,
    input  logic          m_ready_x,
    output logic [WD-1:0] m_data_f,
    output logic          m_valid_f,
    input  logic          m_ready_f,
    input  logic [WY-1:0] s_data_y,
    input  logic          s_valid_y,
    output logic          s_ready_y,
    input  logic          stall_x,
    input  logic          stall_f,
    input  logic          stall_y,
    input  logic [2:0]    res_addr,
    output logic [WY-1:0] res_data,
    output logic [2:0]    y_cnt,
    output state_e        dbg_state
);

    localparam int RES = res_depth(N, M);

    state_e        state_q;
    state_e        state_d;
    logic [2:0]    y_cnt_q;
    logic [2:0]    y_cnt_d;
    logic [WY-1:0] res_q [RES];
    logic [WY-1:0] res_d [RES];
    logic          start_acc;
    logic          run;
    logic          x_all_sent;
    logic          f_all_sent;
    logic          x_wr;
    logic          f_wr;
    logic          y_hs;

    assign run  = (state_q == ST_RUN);
    assign x_wr = cfg_wr_en && !cfg_sel && (state_q == ST_IDLE);
    assign f_wr = cfg_wr_en &&  cfg_sel && (state_q == ST_IDLE);

    stream_src #(
        .DEPTH (N),
        .WD    (WD),
        .AW    (3)
    ) u_src_x (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_acc),
        .run      (run),
        .stall    (stall_x),
        .ready    (m_ready_x),
        .wr_en    (x_wr),
        .wr_addr  (cfg_addr),
        .wr_data  (cfg_data),
        .data     (m_data_x),
        .valid    (m_valid_x),
        .all_sent (x_all_sent)
    );

    stream_src #(
        .DEPTH (M),
        .WD    (WD),
        .AW    (3)
    ) u_src_f (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_acc),
        .run      (run),
        .stall    (stall_f),
        .ready    (m_ready_f),
        .wr_en    (f_wr),
        .wr_addr  (cfg_addr),
        .wr_data  (cfg_data),
        .data     (m_data_f),
        .valid    (m_valid_f),
        .all_sent (f_all_sent)
    );

    // Handshake contract on all three streams: a beat transfers on a rising
    // clk edge where valid and ready are both high; stalls gate valid/ready only.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        y_cnt_d   = y_cnt_q;
        res_d     = res_q;
        s_ready_y = run && (y_cnt_q < 3'(RES)) && !stall_y;
        y_hs      = s_valid_y && s_ready_y;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    start_acc = 1'b1;
                end
            end
            ST_RUN: begin
                if (x_all_sent && f_all_sent && (y_cnt_q == 3'(RES))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_acc) begin
            y_cnt_d = '0;
            for (int i = 0; i < RES; i++) begin
                res_d[i] = '0;
            end
        end else if (y_hs) begin
            for (int i = 0; i < RES; i++) begin
                if (y_cnt_q == 3'(i)) begin
                    res_d[i] = s_data_y;
                end
            end
            y_cnt_d = y_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            y_cnt_q <= '0;
            for (int i = 0; i < RES; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            y_cnt_q <= y_cnt_d;
            res_q   <= res_d;
        end
    end

    // Out-of-range read addresses fall through to zero.
    always_comb begin
        res_data = '0;
        for (int i = 0; i < RES; i++) begin
            if (int'(res_addr) == i) begin
                res_data = res_q[i];
            end
        end
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign y_cnt     = y_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_8_4_host.sv
// Bench for conv_8_4_host with a behavioural convolution engine attached to
// the x/f/y streams and a result scoreboard checked after each job.
module tb_conv_8_4_host;
    import conv_pkg::*;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int WD = 8;
    localparam int WY = 18;
    localparam int R  = N - M + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_wr_en;
    logic          cfg_sel;
    logic [2:0]    cfg_addr;
    logic [WD-1:0] cfg_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [WD-1:0] m_data_x;
    logic          m_valid_x;
    logic          m_ready_x;
    logic [WD-1:0] m_data_f;
    logic          m_valid_f;
    logic          m_ready_f;
    logic [WY-1:0] s_data_y;
    logic          s_valid_y;
    logic          s_ready_y;
    logic          stall_x;
    logic          stall_f;
    logic          stall_y;
    logic [2:0]    res_addr;
    logic [WY-1:0] res_data;
    logic [2:0]    y_cnt;
    state_e        dbg_state;

    conv_8_4_host #(.N(N), .M(M), .WD(WD), .WY(WY)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_wr_en (cfg_wr_en),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .m_data_x  (m_data_x),
        .m_valid_x (m_valid_x),
        .m_ready_x (m_ready_x),
        .m_data_f  (m_data_f),
        .m_valid_f (m_valid_f),
        .m_ready_f (m_ready_f),
        .s_data_y  (s_data_y),
        .s_valid_y (s_valid_y),
        .s_ready_y (s_ready_y),
        .stall_x   (stall_x),
        .stall_f   (stall_f),
        .stall_y   (stall_y),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .y_cnt     (y_cnt),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int x_vec [N];
    int f_vec [M];
    logic [WY-1:0] exp_q [$];

    // Engine and monitor state
    int xr [N];
    int fr [M];
    int xr_n, fr_n, y_n;
    int x_tx, f_tx, y_tx;
    int done_cnt, done_ycnt;
    bit disturb;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int golden(input int k);
        int s = 0;
        for (int j = 0; j < M; j++) s += x_vec[k + j] * f_vec[j];
        return s;
    endfunction

    task automatic idle_inputs();
        cfg_wr_en = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; m_ready_x = 1'b0; m_ready_f = 1'b0;
        s_data_y = '0; s_valid_y = 1'b0;
        stall_x = 1'b0; stall_f = 1'b0; stall_y = 1'b0;
    endtask

    // Driver tasks
    task automatic cfg_write(input bit sel, input int addr, input int val);
        @(negedge clk);
        cfg_wr_en = 1'b1; cfg_sel = sel; cfg_addr = 3'(addr); cfg_data = WD'(val);
        @(posedge clk);
        #1 cfg_wr_en = 1'b0;
    endtask

    task automatic load_vectors();
        for (int i = 0; i < N; i++) cfg_write(1'b0, i, x_vec[i]);
        for (int j = 0; j < M; j++) cfg_write(1'b1, j, f_vec[j]);
    endtask

    // One clock: drive inputs at negedge, record handshakes just before posedge.
    task automatic step(input bit rnd);
        int s;
        @(negedge clk);
        stall_x   = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        stall_f   = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        stall_y   = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        m_ready_x = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        m_ready_f = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (disturb) begin
            start     = 1'b1;
            cfg_wr_en = 1'b1;
            cfg_sel   = 1'($urandom_range(0, 1));
            cfg_addr  = 3'($urandom_range(0, 7));
            cfg_data  = WD'($urandom_range(0, 255));
        end else begin
            start     = 1'b0;
            cfg_wr_en = 1'b0;
        end
        if (y_n < R && fr_n == M && xr_n >= y_n + M) begin
            s = 0;
            for (int j = 0; j < M; j++) s += xr[y_n + j] * fr[j];
            s_valid_y = 1'b1;
            s_data_y  = WY'(s);
        end else begin
            s_valid_y = 1'b0;
            s_data_y  = '0;
        end
        #1;
        if (stall_x) check("stall_x_gate", int'(m_valid_x), 0);
        if (stall_y) check("stall_y_gate", int'(s_ready_y), 0);
        if (m_valid_x && m_ready_x) begin
            xr[xr_n] = int'($signed(m_data_x)); xr_n++; x_tx++;
        end
        if (m_valid_f && m_ready_f) begin
            fr[fr_n] = int'($signed(m_data_f)); fr_n++; f_tx++;
        end
        if (s_valid_y && s_ready_y) begin
            y_n++; y_tx++;
        end
        if (done) begin
            done_cnt++; done_ycnt = int'(y_cnt);
        end
        @(posedge clk);
    endtask

    task automatic start_job();
        xr_n = 0; fr_n = 0; y_n = 0;
        x_tx = 0; f_tx = 0; y_tx = 0;
        done_cnt = 0; done_ycnt = 0;
        for (int k = 0; k < N; k++) exp_q.push_back(WY'((k < R) ? golden(k) : 0));
        @(negedge clk);
        idle_inputs();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    // Scoreboard: run to completion, then pop one expected entry per address.
    task automatic finish_job(input bit rnd, input string tag);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 1000) begin
            step(rnd);
            cyc++;
        end
        disturb = 1'b0;
        check({tag, "_timeout"}, int'(cyc < 1000), 1);
        step(1'b0);
        @(negedge clk);
        idle_inputs();
        #1;
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_ycnt_at_done"}, done_ycnt, R);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_x_tx"}, x_tx, N);
        check({tag, "_f_tx"}, f_tx, M);
        check({tag, "_y_tx"}, y_tx, R);
        check({tag, "_ycnt_kept"}, int'(y_cnt), R);
        for (int a = 0; a < N; a++) begin
            logic [WY-1:0] e;
            res_addr = 3'(a);
            #1;
            e = exp_q.pop_front();
            check({tag, "_res"}, int'($signed(res_data)), int'($signed(e)));
        end
    endtask

    task automatic run_job(input bit rnd, input string tag);
        start_job();
        finish_job(rnd, tag);
    endtask

    initial begin
        idle_inputs();
        res_addr = '0;
        disturb  = 1'b0;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_state", int'(dbg_state), int'(ST_IDLE));
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_vx", int'(m_valid_x), 0);
        check("rst_vf", int'(m_valid_f), 0);
        check("rst_ry", int'(s_ready_y), 0);
        check("rst_dx", int'(m_data_x), 0);
        check("rst_df", int'(m_data_f), 0);
        check("rst_ycnt", int'(y_cnt), 0);
        for (int a = 0; a < N; a++) begin
            res_addr = 3'(a);
            #1 check("rst_res", int'(res_data), 0);
        end

        // Ramp with unit filter; out-of-range f writes must not land anywhere
        for (int i = 0; i < N; i++) x_vec[i] = i + 1;
        for (int j = 0; j < M; j++) f_vec[j] = 1;
        load_vectors();
        cfg_write(1'b1, 5, 99);
        cfg_write(1'b1, 7, -3);
        run_job(1'b0, "ramp");

        // Extreme negative operands
        for (int i = 0; i < N; i++) x_vec[i] = -128;
        for (int j = 0; j < M; j++) f_vec[j] = -128;
        load_vectors();
        run_job(1'b0, "neg128");

        // Start and cfg writes during a job are ignored; buffers then reused as-is
        for (int i = 0; i < N; i++) x_vec[i] = $urandom_range(0, 255) - 128;
        for (int j = 0; j < M; j++) f_vec[j] = $urandom_range(0, 255) - 128;
        load_vectors();
        start_job();
        disturb = 1'b1;
        finish_job(1'b1, "disturb");
        run_job(1'b0, "reuse");

        // Reset after exactly three x transfers aborts the job
        for (int i = 0; i < N; i++) x_vec[i] = i * 3 - 10;
        for (int j = 0; j < M; j++) f_vec[j] = 2 - j;
        load_vectors();
        start_job();
        for (int c = 0; c < 50 && x_tx < 3; c++) step(1'b0);
        check("abort_x_tx", x_tx, 3);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_vx", int'(m_valid_x), 0);
        check("abort_vf", int'(m_valid_f), 0);
        check("abort_ry", int'(s_ready_y), 0);
        check("abort_state", int'(dbg_state), int'(ST_IDLE));
        check("abort_busy", int'(busy), 0);
        check("abort_ycnt", int'(y_cnt), 0);
        repeat (N) void'(exp_q.pop_front());
        run_job(1'b0, "rerun");

        // y offered under stall_y is never accepted
        for (int i = 0; i < N; i++) x_vec[i] = $urandom_range(0, 255) - 128;
        for (int j = 0; j < M; j++) f_vec[j] = $urandom_range(0, 255) - 128;
        load_vectors();
        start_job();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            m_ready_x = 1'b0; m_ready_f = 1'b0;
            s_valid_y = 1'b1; s_data_y = WY'(123); stall_y = 1'b1;
            #1 check("ystall_ready", int'(s_ready_y), 0);
            @(posedge clk);
        end
        #1 check("ystall_ycnt", int'(y_cnt), 0);
        finish_job(1'b0, "ystall");

        // Random vectors with random per-cycle stalls and backpressure
        for (int jb = 0; jb < 1000; jb++) begin
            for (int i = 0; i < N; i++) x_vec[i] = $urandom_range(0, 255) - 128;
            for (int j = 0; j < M; j++) f_vec[j] = $urandom_range(0, 255) - 128;
            load_vectors();
            run_job(1'b1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
